// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path.
// Holds the default address/data widths, the responder FSM state type and
// the opcodes of the CPU instructions that reach data memory
// (lw, sw, jal stack push).
package cpu_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } mem_state_t;

    // Opcodes of the CPU instructions that generate data-memory requests
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// mem_array: synchronous single-port DEPTH x DATA_W storage.
// The write and the registered read share one port. rdata holds its value
// until the next enabled read, so the owner can hold a response on it.
// Ports:
//   clk    clock
//   en     port enable (access this cycle)
//   we     1 = write wdata to addr, 0 = read addr into rdata
//   addr   word address
//   wdata  write data
//   rdata  registered read data
module mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array or the read register: contents survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU data-memory interface.
// Accepts one request at a time on a valid/ready channel, waits
// WAIT_CYCLES cycles, performs the array access in a single COMMIT cycle,
// then holds the response on a valid/ready channel until it is taken.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   word address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             read data (0 for writes and errors)
//   rsp_err               address out of range
//   busy                  transaction in flight
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DATA_W      = CPU_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int MA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    mem_state_t        state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              in_range;
    logic              mem_en;
    logic [DATA_W-1:0] mem_q;

    // Unsigned compare; always true when DEPTH covers the whole address space
    assign in_range = 32'(addr_q) < 32'(DEPTH);

    // A reset landing on the COMMIT edge aborts the access as well
    assign mem_en = (state == ST_COMMIT) && in_range && !rst;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MA_W)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (we_q),
        .addr  (addr_q[MA_W-1:0]),
        .wdata (wdata_q),
        .rdata (mem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= '0;
                        state   <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_COMMIT;
                    end
                end
                ST_WAIT: begin
                    // cnt steps 1..WAIT_CYCLES; the last step leaves WAIT
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WAIT_CYCLES - 1)) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    err_q <= !in_range;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        err_q <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign rsp_err   = err_q;

    // The read register is untouched during RESP, so gating it here keeps the
    // data stable while forcing 0 for writes, errors and outside RESP.
    assign rsp_rdata = (state == ST_RESP && !we_q && !err_q) ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Three instances share the request
// payload, rsp_ready and reset but have private req_valid lines:
//   dut 0: WAIT_CYCLES=2, DEPTH=256
//   dut 1: WAIT_CYCLES=2, DEPTH=128
//   dut 2: WAIT_CYCLES=0, DEPTH=256
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_valid = '0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_ready = 1'b1;
    logic [2:0] req_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_d0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u_d1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]));

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_d2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2]));

    // One full transaction with rsp_ready held high. lat is the cycle number
    // (1 = cycle right after the accepting edge) in which rsp_valid is first
    // seen; acc is the cycle stamp of the accepting edge.
    task automatic txn(input int s, input logic we, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic er, output int lat, output int acc);
        int n;
        rsp_ready = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid[s] = 1'b0;
        lat = 1;
        while (!rsp_valid[s] && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (n >= 50 || lat >= 50) begin
            checks++; errors++;
            $display("FAIL txn_timeout dut=%0d addr=%h ready_wait=%0d lat=%0d required < 50", s, a, n, lat);
        end
        rd = rsp_rdata[s];
        er = rsp_err[s];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_ready[i], rsp_valid[i], rsp_err[i], busy[i]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_ctrl dut=%0d got rdy/vld/err/busy=%b required 1000", i,
                         {req_ready[i], rsp_valid[i], rsp_err[i], busy[i]});
            end
            checks++;
            if (rsp_rdata[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_rdata dut=%0d got %h required 00", i, rsp_rdata[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic er; int lat, acc;
        txn(0, 1'b1, 8'h10, 8'hA5, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== 8'h00) begin
            errors++;
            $display("FAIL wr_rsp got err=%b rdata=%h required err=0 rdata=00", er, rd);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL wr_latency got %0d required 4", lat);
        end
        txn(0, 1'b0, 8'h10, 8'h00, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== 8'hA5) begin
            errors++;
            $display("FAIL rd_rsp got err=%b rdata=%h required err=0 rdata=a5", er, rd);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL rd_latency got %0d required 4", lat);
        end
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 8'h10; req_wdata = 8'h00;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 8'hA5 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdata=%h rdy=%b required vld=1 rdata=a5 rdy=0",
                         i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b busy=%b required vld=0 rdy=1 busy=0",
                     rsp_valid[0], req_ready[0], busy[0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] rd; logic er; int lat, acc;
        txn(1, 1'b1, 8'h00, 8'h3C, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL oor_prewrite got err=%b required 0", er);
        end
        txn(1, 1'b1, 8'h80, 8'hFF, rd, er, lat, acc);
        checks++;
        if (er !== 1'b1 || rd !== 8'h00) begin
            errors++;
            $display("FAIL oor_write got err=%b rdata=%h required err=1 rdata=00", er, rd);
        end
        checks++;
        if (rsp_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_clear got %b required 0", rsp_err[1]);
        end
        txn(1, 1'b0, 8'h00, 8'h00, rd, er, lat, acc);
        checks++;
        if (er !== 1'b0 || rd !== 8'h3C) begin
            errors++;
            $display("FAIL oor_read0 got err=%b rdata=%h required err=0 rdata=3c", er, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd [4]; logic er [4]; int lat [4]; int acc [4];
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_rd[2] = 8'h11; exp_rd[3] = 8'h22;
        txn(2, 1'b1, 8'h01, 8'h11, rd[0], er[0], lat[0], acc[0]);
        txn(2, 1'b1, 8'h02, 8'h22, rd[1], er[1], lat[1], acc[1]);
        txn(2, 1'b0, 8'h01, 8'h00, rd[2], er[2], lat[2], acc[2]);
        txn(2, 1'b0, 8'h02, 8'h00, rd[3], er[3], lat[3], acc[3]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== exp_rd[i] || er[i] !== 1'b0 || lat[i] != 2) begin
                errors++;
                $display("FAIL b2b_txn%0d got rdata=%h err=%b lat=%0d required rdata=%h err=0 lat=2",
                         i, rd[i], er[i], lat[i], exp_rd[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin
                errors++;
                $display("FAIL b2b_period%0d got %0d required 3", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [7:0] rd; logic er; int lat, acc;
        txn(0, 1'b1, 8'h20, 8'h00, rd, er, lat, acc);
        req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstw_accept got busy=%b required 1", busy[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({req_ready[0], rsp_valid[0], rsp_err[0], busy[0]} !== 4'b1000 || rsp_rdata[0] !== 8'h00) begin
            errors++;
            $display("FAIL rstw_outputs got rdy/vld/err/busy=%b rdata=%h required 1000 rdata=00",
                     {req_ready[0], rsp_valid[0], rsp_err[0], busy[0]}, rsp_rdata[0]);
        end
        txn(0, 1'b0, 8'h20, 8'h00, rd, er, lat, acc);
        checks++;
        if (rd !== 8'h00 || er !== 1'b0) begin
            errors++;
            $display("FAIL rstw_read got rdata=%h err=%b required rdata=00 err=0", rd, er);
        end
    endtask

    task automatic test_stack_push();
        logic [7:0] rd; logic er; int lat, acc, n;
        rsp_ready = 1'b0;
        req_we = 1'b1; req_addr = 8'hFF; req_wdata = 8'h05;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL push_rsp got vld=%b err=%b required vld=1 err=0", rsp_valid[0], rsp_err[0]);
        end
        // Stray request while the response is pending must be ignored
        req_wdata = 8'h99;
        req_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL push_stray got rdy=%b vld=%b required rdy=0 vld=1", req_ready[0], rsp_valid[0]);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL push_no_extra cyc=%0d got vld=%b busy=%b required vld=0 busy=0",
                         i, rsp_valid[0], busy[0]);
            end
            @(posedge clk); #1;
        end
        txn(0, 1'b0, 8'hFF, 8'h00, rd, er, lat, acc);
        checks++;
        if (rd !== 8'h05 || er !== 1'b0) begin
            errors++;
            $display("FAIL push_read got rdata=%h err=%b required rdata=05 err=0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_wait();
        test_stack_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
